leb128_stream_dec: RTL
======================

// Module: leb128_stream_dec
// PURPOSE
//  Sequencer for the combinational 10-byte LEB128 unpackers (unpack_u64, unpack_i64).
//  Takes a byte stream on a valid/ready interface and collects one encoded value into a
//  zero-cleared byte window. Presents the decoded 64-bit value and its byte length on a
//  valid/ready output. Sits between the byte FIFO of the stream parser and its consumers.
// PARAMETERS
//  MAX_LEN  10  maximum encoded bytes per value, range 1..10 (5 gives a 32-bit decoder)
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  flush      in   1   abort the partial value being collected
//  in_data    in   8   encoded byte; bit7 = continuation (glue) bit
//  in_sgn     in   1   1 = signed decode; sampled with the first byte of each value
//  in_valid   in   1   in_data is valid
//  in_ready   out  1   block accepts the byte this cycle
//  out_data   out  64  decoded value (sign-extended when signed)
//  out_len    out  4   encoded bytes consumed, 1..MAX_LEN
//  out_err    out  1   value terminated abnormally (see CONFIGURATION)
//  out_valid  out  1   out_data/out_len/out_err are valid
//  out_ready  in   1   consumer takes the value
// BEHAVIOUR
//  - Reset: state COLLECT, cnt=0, window=0, sgn=0. out_valid=0 and out_err=0. in_ready=0
//    while rst is high. out_data and out_len equal the decode of the zero window (0 and 1).
//  - States: COLLECT, OUT, DRAIN. in_ready = (state!=OUT) & !flush.
//  - Accept on in_valid&in_ready. In COLLECT, the byte goes to window slot cnt and cnt increments.
//    Slots at and above MAX_LEN always read 0.
//  - Termination: the accepted byte has bit7=0, or cnt==MAX_LEN-1. The last slot is stored
//    with bit7 forced to 0, so the unpacker terminates there. Next state is OUT.
//  - Latency: out_valid rises on the edge that accepts the terminating byte.
//  - Output is combinational from the window register: sgn ? i64 result : u64 result. It stays
//    stable while out_valid=1.
//  - out_valid&out_ready: window cleared, cnt=0, state COLLECT. in_ready rises the next cycle
//    (no bypass), so one value takes at most n+1 cycles.
//  - out_valid is never withdrawn without out_ready.
//  - flush in COLLECT or DRAIN: window cleared, cnt=0, state COLLECT. A byte offered in the
//    same cycle is not accepted. flush is ignored in OUT.
//  - rst mid-value discards all partial bytes. A pending output is lost.
// CONFIGURATION
//  LEB128_OVERFLOW_CHECK_EN defined:
//   - Forced termination with a set continuation bit gives out_err=1. Next state is DRAIN:
//     out_valid=1 as in OUT, then the block discards accepted bytes up to and including the
//     next byte with bit7=0, and returns to COLLECT.
//   - When MAX_LEN=10 and the 10th byte is used: unsigned requires byte[6:1]==0; signed
//     requires byte[6:0] to be 0x00 or 0x7F. Otherwise out_err=1. No drain for this case.
//  Undefined: out_err tied 0, no DRAIN state. Bytes after forced termination start a new value.
// STRUCTURE
//  leb128_pkg: LEB128_MAX_BYTES=10, LEN_W=4, state enum {COLLECT,OUT,DRAIN}.
//  Sub-module leb128_window: byte window register, slot counter, clear/force-glue logic.
//  Top level: FSM, handshakes, unpack_u64 plus unpack_i64 instances, output mux.
// TESTING
//  1 unsigned 0x02 -> out_data=0x2, out_len=1, out_valid on the edge after accept.
//  2 signed 0x7F -> out_data=0xFFFF_FFFF_FFFF_FFFF, out_len=1.
//  3 unsigned E5 8E 26 with idle in_valid gaps -> out_data=624485 (0x9_8765), out_len=3.
//  4 signed C0 BB 78 -> out_data=0xFFFF_FFFF_FFFE_1DC0 (-123456), out_len=3.
//  5 out_ready low for 5 cycles -> out_data/out_len stable, in_ready=0. Byte after release
//    starts a new value.
//  6 Ten 0xFF then 0x01, 0x05:
//    - with macro: out_err=1, out_len=10; 0x01 is drained; 0x05 decodes to 5.
//    - without macro: out_err=0; 0x01 decodes to 1; 0x05 decodes to 5.
//  7 flush after E5 8E, then 0x03 -> out_data=3, out_len=1.

Source files
------------

// File: rtl/leb128_pkg.sv
// -----------------------------------------------------------------------------
// leb128_pkg
// Shared constants, state encoding and the combinational LEB128 decode helper
// used by the stream decoder and its unpacker instances.
//   LEB128_MAX_BYTES : widest encoding the window can hold (10 bytes = 64 bits)
//   LEN_W            : width of a byte count 0..10
//   WIN_W            : width of the flattened byte window
//   state_t          : sequencer states COLLECT / OUT / DRAIN
//   leb128Decode     : window -> {value, encoded length}
// -----------------------------------------------------------------------------
package leb128_pkg;

  localparam int LEB128_MAX_BYTES = 10;
  localparam int LEN_W            = 4;
  localparam int WIN_W            = LEB128_MAX_BYTES * 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    OUT     = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0]      value;
    logic [LEN_W-1:0] len;
  } decode_t;

  // Walks the window from slot 0 and stops at the first byte whose
  // continuation bit is clear. Payload bits beyond bit 63 fall off the top.
  // A window with no terminator reports the full 10-byte length; the
  // sequencer never produces one because the last slot is stored unglued.
  function automatic decode_t leb128Decode(input logic [WIN_W-1:0] win,
                                           input logic isSigned);
    decode_t    res;
    logic       done;
    logic [7:0] b;
    int         shift;
    res.value = '0;
    res.len   = LEN_W'(LEB128_MAX_BYTES);
    done      = 1'b0;
    for (int i = 0; i < LEB128_MAX_BYTES; i++) begin
      b = 8'(win >> (8 * i));
      if (!done) begin
        res.value = res.value | (64'(b[6:0]) << (7 * i));
        if (!b[7]) begin
          done    = 1'b1;
          res.len = LEN_W'(i + 1);
        end
      end
    end
    // Sign extension only matters while the payload is narrower than 64 bits.
    shift = 7 * int'(res.len);
    if (isSigned && (shift < 64) && res.value[6'(shift - 1)]) begin
      res.value = res.value | ({64{1'b1}} << shift);
    end
    return res;
  endfunction

endpackage

// File: rtl/leb128_unpack.sv
// -----------------------------------------------------------------------------
// unpack_u64 / unpack_i64
// Purely combinational 10-byte LEB128 unpackers.
//   i_window : 80-bit byte window, slot 0 in bits [7:0]
//   o_value  : decoded value (zero-extended for u64, sign-extended for i64)
//   o_len    : number of encoded bytes up to and including the terminator
// -----------------------------------------------------------------------------
module unpack_u64
  import leb128_pkg::*;
(
  input  logic [WIN_W-1:0] i_window,
  output logic [63:0]      o_value,
  output logic [LEN_W-1:0] o_len
);

  decode_t w_res;

  assign w_res   = leb128Decode(i_window, 1'b0);
  assign o_value = w_res.value;
  assign o_len   = w_res.len;

endmodule

module unpack_i64
  import leb128_pkg::*;
(
  input  logic [WIN_W-1:0] i_window,
  output logic [63:0]      o_value,
  output logic [LEN_W-1:0] o_len
);

  decode_t w_res;

  assign w_res   = leb128Decode(i_window, 1'b1);
  assign o_value = w_res.value;
  assign o_len   = w_res.len;

endmodule

// File: rtl/leb128_window.sv
// -----------------------------------------------------------------------------
// leb128_window
// Byte window register for one LEB128 value under collection.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : zero the window and rewind the slot counter
//   i_wr         : store i_byte into slot o_cnt and advance
//   i_byte       : incoming encoded byte
//   o_window     : flattened window, slots >= MAX_LEN read as zero
//   o_cnt        : index of the next slot to be written
//   o_isLast     : the next write lands in the final slot (MAX_LEN-1)
// -----------------------------------------------------------------------------
module leb128_window
  import leb128_pkg::*;
#(
  parameter int MAX_LEN = LEB128_MAX_BYTES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_wr,
  input  logic [7:0]       i_byte,
  output logic [WIN_W-1:0] o_window,
  output logic [LEN_W-1:0] o_cnt,
  output logic             o_isLast
);

  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       w_storeByte;

  assign o_cnt    = r_cnt;
  assign o_isLast = (r_cnt == LEN_W'(MAX_LEN - 1));

  // The final slot is stored unglued so the unpacker always finds a
  // terminator inside the window, even for a runaway encoding.
  assign w_storeByte = o_isLast ? {1'b0, i_byte[6:0]} : i_byte;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_wr && (r_cnt < LEN_W'(MAX_LEN))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < LEB128_MAX_BYTES; g++) begin : gSlot
    if (g < MAX_LEN) begin : gUsed
      logic [7:0] r_slot;
      always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
          r_slot <= '0;
        end else if (i_wr && (r_cnt == LEN_W'(g))) begin
          r_slot <= w_storeByte;
        end
      end
      assign o_window[g*8 +: 8] = r_slot;
    end else begin : gZero
      assign o_window[g*8 +: 8] = 8'h00;
    end
  end

endmodule

// File: rtl/leb128_stream_dec.sv
// -----------------------------------------------------------------------------
// leb128_stream_dec
// Collects one LEB128-encoded value from a byte stream and presents the
// decoded 64-bit result on a valid/ready output.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : abandon the partial value (ignored while a result is held)
//   in_data    : encoded byte, bit7 = continuation
//   in_sgn     : signed decode, captured with the first byte of a value
//   in_valid   : in_data valid
//   in_ready   : byte accepted this cycle when in_valid is high
//   out_data   : decoded value
//   out_len    : encoded byte count 1..MAX_LEN
//   out_err    : abnormal termination
//   out_valid  : out_data/out_len/out_err valid
//   out_ready  : consumer takes the result
// Optional feature macro: LEB128_OVERFLOW_CHECK_EN enables out_err and the
// DRAIN state that discards the tail of an over-long encoding.
// -----------------------------------------------------------------------------
module leb128_stream_dec
  import leb128_pkg::*;
#(
  parameter int MAX_LEN = LEB128_MAX_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [7:0]       in_data,
  input  logic             in_sgn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      out_data,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_sgn;
  logic             w_accept;
  logic             w_collectAcc;
  logic             w_term;
  logic             w_outFire;
  logic             w_clear;
  logic             w_isLast;
  logic [WIN_W-1:0] w_window;
  logic [LEN_W-1:0] w_cnt;
  logic [63:0]      w_uValue;
  logic [63:0]      w_iValue;
  logic [LEN_W-1:0] w_uLen;
  logic [LEN_W-1:0] w_iLen;

  assign in_ready     = !rst && (r_state != OUT) && !flush;
  assign out_valid    = (r_state == OUT);
  assign w_accept     = in_valid && in_ready;
  assign w_collectAcc = w_accept && (r_state == COLLECT);
  assign w_term       = w_collectAcc && (!in_data[7] || w_isLast);
  assign w_outFire    = out_valid && out_ready;
  assign w_clear      = w_outFire || (flush && (r_state != OUT));

  leb128_window #(
    .MAX_LEN (MAX_LEN)
  ) uWindow (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (w_clear),
    .i_wr     (w_collectAcc),
    .i_byte   (in_data),
    .o_window (w_window),
    .o_cnt    (w_cnt),
    .o_isLast (w_isLast)
  );

  unpack_u64 uUnpackU (
    .i_window (w_window),
    .o_value  (w_uValue),
    .o_len    (w_uLen)
  );

  unpack_i64 uUnpackI (
    .i_window (w_window),
    .o_value  (w_iValue),
    .o_len    (w_iLen)
  );

  // Output is a pure function of the window, so it holds steady while the
  // window is frozen in OUT.
  assign out_data = r_sgn ? w_iValue : w_uValue;
  assign out_len  = r_sgn ? w_iLen : w_uLen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn <= 1'b0;
    end else if (w_collectAcc && (w_cnt == '0)) begin
      r_sgn <= in_sgn;
    end
  end

`ifdef LEB128_OVERFLOW_CHECK_EN
  logic       r_glueErr;
  logic       w_rangeErr;
  logic [7:0] w_lastSlot;

  // Remembers that the value was cut off with its continuation bit still
  // set; also selects the DRAIN path once the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glueErr <= 1'b0;
    end else if (w_term) begin
      r_glueErr <= in_data[7];
    end else if (w_clear) begin
      r_glueErr <= 1'b0;
    end
  end

  // A 10th byte may only carry bit 63: unsigned allows nothing above bit 0,
  // signed allows only an all-zero or all-one extension.
  assign w_lastSlot = w_window[WIN_W-1 -: 8];

  always_comb begin
    w_rangeErr = 1'b0;
    if ((MAX_LEN == LEB128_MAX_BYTES) && (out_len == LEN_W'(LEB128_MAX_BYTES))) begin
      if (r_sgn) begin
        w_rangeErr = !((w_lastSlot[6:0] == 7'h00) || (w_lastSlot[6:0] == 7'h7F));
      end else begin
        w_rangeErr = |w_lastSlot[6:1];
      end
    end
  end

  assign out_err = r_glueErr || w_rangeErr;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // flush cannot coincide with an accept because in_ready is gated by it,
  // so COLLECT needs no explicit flush branch.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      COLLECT: begin
        if (w_term) begin
          w_nextState = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
`ifdef LEB128_OVERFLOW_CHECK_EN
          w_nextState = r_glueErr ? DRAIN : COLLECT;
`else
          w_nextState = COLLECT;
`endif
        end
      end
      DRAIN: begin
        if (flush || (w_accept && !in_data[7])) begin
          w_nextState = COLLECT;
        end
      end
      default: w_nextState = COLLECT;
    endcase
  end

endmodule
